// File: rtl/package_sorter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : package_sorter_pkg
// Purpose  : Shared widths, weight-group boundaries and helpers for the
//            package sorter (top level and weight classifier).
// Contents : WEIGHT_W / COUNT_W / GRP_W widths, inclusive upper bounds of
//            groups 1..5, group encoding type, saturating increment.
// Revision : 1.0 - initial release
// ============================================================================
package package_sorter_pkg;

  localparam int WEIGHT_W  = 12;
  localparam int COUNT_W   = 8;
  localparam int GRP_W     = 3;
  localparam int NUM_GRPS  = 6;

  // Inclusive upper bound of each weight group; group 6 runs to full scale.
  localparam logic [WEIGHT_W-1:0] GRP1_MAX = 12'd200;
  localparam logic [WEIGHT_W-1:0] GRP2_MAX = 12'd500;
  localparam logic [WEIGHT_W-1:0] GRP3_MAX = 12'd800;
  localparam logic [WEIGHT_W-1:0] GRP4_MAX = 12'd1000;
  localparam logic [WEIGHT_W-1:0] GRP5_MAX = 12'd2000;

  localparam logic [COUNT_W-1:0]  COUNT_MAX = {COUNT_W{1'b1}};

  typedef logic [GRP_W-1:0] grp_t;

  localparam grp_t GRP_EMPTY = 3'd0;

  // Increment that sticks at full scale instead of wrapping.
  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    return (v == COUNT_MAX) ? v : v + {{(COUNT_W-1){1'b0}}, 1'b1};
  endfunction

endpackage
`default_nettype wire

// File: rtl/package_sorter_classifier.sv
`default_nettype none
// ============================================================================
// Module   : weight_classifier
// Purpose  : Purely combinational mapping of a scale reading to its weight
//            group (0 = scale empty, 1..6 = weight bands).
// Ports    : weight - unsigned scale reading
//            grp    - group number of that reading
// Revision : 1.0 - initial release
// ============================================================================
module weight_classifier
  import package_sorter_pkg::*;
(
  input  logic [WEIGHT_W-1:0] weight,
  output logic [GRP_W-1:0]    grp
);

  always_comb begin
    grp = GRP_EMPTY;
    if (weight == '0)
      grp = GRP_EMPTY;
    else if (weight <= GRP1_MAX)
      grp = 3'd1;
    else if (weight <= GRP2_MAX)
      grp = 3'd2;
    else if (weight <= GRP3_MAX)
      grp = 3'd3;
    else if (weight <= GRP4_MAX)
      grp = 3'd4;
    else if (weight <= GRP5_MAX)
      grp = 3'd5;
    else
      grp = 3'd6;
  end

endmodule
`default_nettype wire

// File: rtl/package_sorter.sv
`default_nettype none
// ============================================================================
// Module   : package_sorter
// Purpose  : Counts packages per weight group. A package is counted once,
//            on the first edge it is seen after the scale has been empty;
//            the group of the current reading is registered for display.
// Ports    : CLK        - rising-edge clock
//            weight     - scale reading, 0 = no package
//            Reset      - asynchronous active-high reset
//            grp1..grp6 - saturating package count per group
//            currentGrp - registered group of the current reading
// Revision : 1.0 - initial release
// ============================================================================
module package_sorter
  import package_sorter_pkg::*;
(
  input  logic                CLK,
  input  logic [WEIGHT_W-1:0] weight,
  input  logic                Reset,
  output logic [COUNT_W-1:0]  grp1,
  output logic [COUNT_W-1:0]  grp2,
  output logic [COUNT_W-1:0]  grp3,
  output logic [COUNT_W-1:0]  grp4,
  output logic [COUNT_W-1:0]  grp5,
  output logic [COUNT_W-1:0]  grp6,
  output logic [GRP_W-1:0]    currentGrp
);

  logic [GRP_W-1:0]                  w_grp;
  logic                              w_empty;
  logic                              w_count_en;
  logic                              r_armed;
  logic [GRP_W-1:0]                  r_cur_grp;
  logic [NUM_GRPS:1][COUNT_W-1:0]    w_cnts;

  weight_classifier u_classifier (
    .weight (weight),
    .grp    (w_grp)
  );

  assign w_empty    = (weight == '0);
  // A nonzero reading only counts when the scale went empty since the last
  // counted package; this makes a package resting on the scale count once.
  assign w_count_en = !w_empty && r_armed;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_armed   <= 1'b1;
      r_cur_grp <= GRP_EMPTY;
    end else begin
      r_cur_grp <= w_grp;
      if (w_empty)
        r_armed <= 1'b1;
      else if (r_armed)
        r_armed <= 1'b0;
    end
  end

  // One counter per group; only the counter matching the classification of
  // a newly arrived package moves, so at most one changes per cycle.
  for (genvar i = 1; i <= NUM_GRPS; i++) begin : g_cnt
    logic [COUNT_W-1:0] r_cnt;

    always_ff @(posedge CLK or posedge Reset) begin
      if (Reset)
        r_cnt <= '0;
      else if (w_count_en && (w_grp == GRP_W'(i)))
        r_cnt <= sat_inc(r_cnt);
    end

    assign w_cnts[i] = r_cnt;
  end

  assign grp1       = w_cnts[1];
  assign grp2       = w_cnts[2];
  assign grp3       = w_cnts[3];
  assign grp4       = w_cnts[4];
  assign grp5       = w_cnts[5];
  assign grp6       = w_cnts[6];
  assign currentGrp = r_cur_grp;

endmodule
`default_nettype wire

// File: tb/tb_package_sorter.sv
`default_nettype none
// ============================================================================
// Module   : tb_package_sorter
// Purpose  : Self-checking bench for package_sorter: a table of weight steps
//            with hand-computed counts, plus directed saturation and
//            asynchronous-reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_package_sorter;

  logic        CLK;
  logic [11:0] weight;
  logic        Reset;
  logic [7:0]  grp1, grp2, grp3, grp4, grp5, grp6;
  logic [2:0]  currentGrp;

  int tests_run;
  int tests_failed;

  typedef struct {
    bit rst;      // pulse Reset (weight held at w) before the step
    int w;        // weight applied
    int n;        // edges to hold it
    int g1, g2, g3, g4, g5, g6;
    int cg;
  } vec_t;

  vec_t vecs[$];

  package_sorter dut (
    .CLK        (CLK),
    .weight     (weight),
    .Reset      (Reset),
    .grp1       (grp1),
    .grp2       (grp2),
    .grp3       (grp3),
    .grp4       (grp4),
    .grp5       (grp5),
    .grp6       (grp6),
    .currentGrp (currentGrp)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input int act, input int exp);
    tests_run++;
    if (act != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input int g1, input int g2,
                           input int g3, input int g4, input int g5,
                           input int g6, input int cg);
    check({tag, " grp1"}, int'(grp1), g1);
    check({tag, " grp2"}, int'(grp2), g2);
    check({tag, " grp3"}, int'(grp3), g3);
    check({tag, " grp4"}, int'(grp4), g4);
    check({tag, " grp5"}, int'(grp5), g5);
    check({tag, " grp6"}, int'(grp6), g6);
    check({tag, " currentGrp"}, int'(currentGrp), cg);
  endtask

  // Advance n rising edges, then settle 1 time unit past the last edge.
  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  function automatic void add(input bit rst, input int w, input int n,
                              input int g1, input int g2, input int g3,
                              input int g4, input int g5, input int g6,
                              input int cg);
    vec_t v;
    v.rst = rst; v.w = w; v.n = n;
    v.g1 = g1; v.g2 = g2; v.g3 = g3; v.g4 = g4; v.g5 = g5; v.g6 = g6;
    v.cg = cg;
    vecs.push_back(v);
  endfunction

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    Reset        = 1'b1;
    weight       = 12'd0;

    // Reset with empty scale, then the basic weight sequence.
    add(1,    0, 4,  0, 0, 0, 0, 0, 0, 0);
    add(0,  250, 4,  0, 1, 0, 0, 0, 0, 2);
    add(0,    0, 4,  0, 1, 0, 0, 0, 0, 0);
    add(0,  300, 4,  0, 2, 0, 0, 0, 0, 2);
    add(0,    0, 4,  0, 2, 0, 0, 0, 0, 0);
    add(0,  501, 4,  0, 2, 1, 0, 0, 0, 3);
    add(0, 1013, 4,  0, 2, 1, 0, 0, 0, 5);   // group change, no new count
    // Boundary sweep from a clean reset.
    add(1,    0, 2,  0, 0, 0, 0, 0, 0, 0);
    add(0,    1, 2,  1, 0, 0, 0, 0, 0, 1);
    add(0,    0, 1,  1, 0, 0, 0, 0, 0, 0);
    add(0,  200, 2,  2, 0, 0, 0, 0, 0, 1);
    add(0,    0, 1,  2, 0, 0, 0, 0, 0, 0);
    add(0,  201, 2,  2, 1, 0, 0, 0, 0, 2);
    add(0,    0, 1,  2, 1, 0, 0, 0, 0, 0);
    add(0,  500, 2,  2, 2, 0, 0, 0, 0, 2);
    add(0,    0, 1,  2, 2, 0, 0, 0, 0, 0);
    add(0,  501, 2,  2, 2, 1, 0, 0, 0, 3);
    add(0,    0, 1,  2, 2, 1, 0, 0, 0, 0);
    add(0,  800, 2,  2, 2, 2, 0, 0, 0, 3);
    add(0,    0, 1,  2, 2, 2, 0, 0, 0, 0);
    add(0,  801, 2,  2, 2, 2, 1, 0, 0, 4);
    add(0,    0, 1,  2, 2, 2, 1, 0, 0, 0);
    add(0, 1000, 2,  2, 2, 2, 2, 0, 0, 4);
    add(0,    0, 1,  2, 2, 2, 2, 0, 0, 0);
    add(0, 1001, 2,  2, 2, 2, 2, 1, 0, 5);
    add(0,    0, 1,  2, 2, 2, 2, 1, 0, 0);
    add(0, 2000, 2,  2, 2, 2, 2, 2, 0, 5);
    add(0,    0, 1,  2, 2, 2, 2, 2, 0, 0);
    add(0, 2001, 2,  2, 2, 2, 2, 2, 1, 6);
    add(0,    0, 1,  2, 2, 2, 2, 2, 1, 0);
    add(0, 4095, 2,  2, 2, 2, 2, 2, 2, 6);
    add(0,    0, 1,  2, 2, 2, 2, 2, 2, 0);
    // Package resting on the scale is counted once.
    add(1,    0, 2,  0, 0, 0, 0, 0, 0, 0);
    add(0,  900, 20, 0, 0, 0, 1, 0, 0, 4);
    add(0,    0, 1,  0, 0, 0, 1, 0, 0, 0);
    // Weight present at reset release counts on the first edge.
    add(1,  150, 1,  1, 0, 0, 0, 0, 0, 1);
    add(0,  150, 5,  1, 0, 0, 0, 0, 0, 1);

    tick(1);
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst) begin
        Reset  = 1'b1;
        weight = vecs[i].w[11:0];
        tick(2);
        Reset  = 1'b0;
      end
      weight = vecs[i].w[11:0];
      tick(vecs[i].n);
      check_all($sformatf("vec%0d w=%0d", i, vecs[i].w),
                vecs[i].g1, vecs[i].g2, vecs[i].g3, vecs[i].g4,
                vecs[i].g5, vecs[i].g6, vecs[i].cg);
    end

    // Saturation: 300 packages of weight 100 after a clean reset.
    Reset  = 1'b1;
    weight = 12'd0;
    tick(2);
    Reset  = 1'b0;
    for (int p = 1; p <= 300; p++) begin
      weight = 12'd100;
      tick(1);
      weight = 12'd0;
      tick(1);
      if (p == 254) check_all("sat p254", 254, 0, 0, 0, 0, 0, 0);
      if (p == 255) check_all("sat p255", 255, 0, 0, 0, 0, 0, 0);
    end
    check_all("sat p300", 255, 0, 0, 0, 0, 0, 0);

    // Asynchronous reset mid-cycle with weight 700 and nonzero counts.
    weight = 12'd700;
    tick(1);
    check_all("pre-areset", 255, 0, 1, 0, 0, 0, 3);
    #3;
    Reset = 1'b1;
    #1;
    check_all("areset immediate", 0, 0, 0, 0, 0, 0, 0);
    tick(2);
    check_all("areset held", 0, 0, 0, 0, 0, 0, 0);
    #2;
    Reset = 1'b0;
    tick(1);
    check_all("after release", 0, 0, 1, 0, 0, 0, 3);
    tick(3);
    check_all("after release hold", 0, 0, 1, 0, 0, 0, 3);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/package_sorter.md
PACKAGE_SORTER -- requirements
Module: package_sorter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; the ports SHALL be in this positional order: CLK, weight, Reset, grp1..grp6, currentGrp.
REQ-002 CLK  input  1  rising-edge clock for all state.
REQ-003 Reset  input  1  asynchronous, active-high reset.
REQ-004 weight  input  12  unsigned scale reading; 0 means no package on the scale.
REQ-005 grp1..grp6  output  8 each  registered package count per weight group.
REQ-006 currentGrp  output  3  registered group of the current weight; 0 when the scale is empty.

Function
REQ-007 Classification (combinational) SHALL be:
- 0 -> group 0
- 1-200 -> group 1
- 201-500 -> group 2
- 501-800 -> group 3
- 801-1000 -> group 4
- 1001-2000 -> group 5
- 2001-4095 -> group 6
REQ-008 On every rising CLK edge, currentGrp SHALL load the classification of weight, giving one-cycle latency.
REQ-009 An internal 1-bit "armed" flag SHALL record whether the scale has been empty (weight == 0) since the last counted package.
REQ-010 Counting: on an edge where weight != 0 and armed == 1, the block SHALL increment grpN for N = classification and clear armed, all in that same cycle.
REQ-011 On an edge where weight == 0, the block SHALL set armed = 1 and leave all counts unchanged.
REQ-012 A weight change from one nonzero value to another nonzero value SHALL update currentGrp only; no count SHALL change, even if the group changes.
REQ-013 A package held on the scale for many cycles SHALL be counted exactly once.
REQ-014 Each count SHALL saturate at 255: an increment at 255 leaves the count at 255.
REQ-015 Only one count SHALL change per cycle; the other five SHALL hold.

Reset
REQ-016 Asserting Reset SHALL immediately force grp1..grp6 = 0 and currentGrp = 0, set armed = 1, and hold these values while Reset stays high.
REQ-017 A nonzero weight present when Reset is released SHALL be counted once on the first active edge after release.
REQ-018 Reset asserted mid-operation SHALL discard all counts with no pending increment.

Structure
REQ-019 A shared package SHALL hold the group boundary constants (200, 500, 800, 1000, 2000), WEIGHT_W = 12, COUNT_W = 8 and GRP_W = 3.
REQ-020 The classification SHALL be one combinational sub-module, weight_classifier (weight in, 3-bit group out).
REQ-021 The top level SHALL contain the counters, the armed flag and the currentGrp register.

Verification
REQ-022 Reset with weight = 0; hold 4 cycles -> all counts 0, currentGrp = 0.
REQ-023 Apply the weight sequence 250, 0, 300, 0, 501, 1013, 4 cycles each -> after each step:
- 250: grp2 = 1, currentGrp = 2
- 0: currentGrp = 0
- 300: grp2 = 2
- 0: currentGrp = 0
- 501: grp3 = 1, currentGrp = 3
- 1013: currentGrp = 5, grp5 = 0, all counts unchanged
REQ-024 Boundary sweep: each weight in {1, 200, 201, 500, 501, 800, 801, 1000, 1001, 2000, 2001, 4095}, with 0 between each -> group sequence 1,1,2,2,3,3,4,4,5,5,6,6; grp1..grp6 each = 2.
REQ-025 Hold weight = 900 for 20 cycles -> grp4 = 1 only; currentGrp = 4.
REQ-026 Alternate 0 and 100 for 300 packages -> grp1 saturates at 255.
REQ-027 Assert Reset asynchronously between edges while counts are nonzero and weight = 700 -> outputs go to 0 before the next edge; after release, grp3 = 1.
